// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard / stall controller.
// Holds the MDU timer state encoding, the default MDU latency,
// the GPR index width and the zero-register index.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_LAT_DEF = 8;
  localparam int GPR_W       = 5;

  localparam logic [GPR_W-1:0] REG_ZERO = '0;

endpackage : hazard_stall_ctrl_pkg

// File: rtl/hazard_mdu_timer.sv
// MDU busy-window timer.
// An MDU start in EX opens a busy window of MDU_LAT cycles, beginning
// the cycle after the start. A start that arrives while already busy is
// ignored; the window keeps counting.
// Ports:
//   clk_i   pipeline clock
//   rst_i   synchronous active-high reset
//   start_i MDU op in EX this cycle
//   busy_o  registered busy-window flag
module hazard_mdu_timer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic busy_o
);

  mdu_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts remaining busy cycles after the current one, so the
  // window is exactly MDU_LAT cycles long (MDU_LAT-1 down to 0).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MDU_IDLE: begin
        if (start_i) begin
          state_d = MDU_BUSY;
          cnt_d   = 5'(MDU_LAT - 1);
        end
      end
      MDU_BUSY: begin
        if (cnt_q == 5'd0) begin
          state_d = MDU_IDLE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o = (state_q == MDU_BUSY);

  // Issue logic stalls MDU consumers while busy, so a second start
  // during the window indicates an upstream interlock bug.
  a_no_start_while_busy : assert property (
    @(posedge clk_i) disable iff (rst_i) !((state_q == MDU_BUSY) && start_i)
  );

endmodule : hazard_mdu_timer

// File: rtl/hazard_stall_ctrl.sv
// Central stall / flush controller for the IF/ID and ID/EX registers.
// Detects load-use hazards, HI/LO or MDU hazards against a busy MDU,
// and taken branch/jump redirects; drives enables, clear and bubble
// requests combinationally and keeps saturating performance counters.
// Ports:
//   clk, CLR (sync active-high reset)
//   ID_*  : operands / class of the instruction in ID
//   EX_*  : load, writeback, MDU start and branch outcome in EX
//   PC_EN, IFID_EN, IFID_CLR, IDEX_EN, bb_data, bb_bj : pipeline controls
//   mdu_busy : registered MDU busy window
//   stall_cnt, bubble_cnt, flush_cnt : saturating event counters
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic [GPR_W-1:0] ID_rs,
  input  logic [GPR_W-1:0] ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             ID_hilo_rd,
  input  logic             ID_mdu_op,
  input  logic             EX_MemtoReg,
  input  logic             EX_RegWrite,
  input  logic [GPR_W-1:0] EX_WbRegNum,
  input  logic             EX_mdu_start,
  input  logic             EX_bj_taken,
  output logic             PC_EN,
  output logic             IFID_EN,
  output logic             IFID_CLR,
  output logic             IDEX_EN,
  output logic             bb_data,
  output logic             bb_bj,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic lu_hz, md_hz, hilo_user;
  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d, flush_q, flush_d;

  hazard_mdu_timer #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_timer (
    .clk_i   (clk),
    .rst_i   (CLR),
    .start_i (EX_mdu_start),
    .busy_o  (mdu_busy)
  );

  assign lu_hz = EX_MemtoReg && EX_RegWrite && (EX_WbRegNum != REG_ZERO) &&
                 ((ID_use_rs && (ID_rs == EX_WbRegNum)) ||
                  (ID_use_rt && (ID_rt == EX_WbRegNum)));

  // The start cycle itself must also bubble a HI/LO consumer: the busy
  // flag only rises on the following cycle.
  assign hilo_user = ID_hilo_rd || ID_mdu_op;
  assign md_hz     = (mdu_busy || EX_mdu_start) && hilo_user;

  always_comb begin
    PC_EN    = 1'b1;
    IFID_EN  = 1'b1;
    IFID_CLR = 1'b0;
    IDEX_EN  = 1'b1;
    bb_data  = 1'b0;
    bb_bj    = 1'b0;
    if (EX_bj_taken) begin
      // The ID instruction is wrong-path and dies, so its hazards are moot.
      IFID_CLR = 1'b1;
      IDEX_EN  = 1'b0;
      bb_bj    = 1'b1;
    end else if (lu_hz || md_hz) begin
      PC_EN   = 1'b0;
      IFID_EN = 1'b0;
      IDEX_EN = 1'b0;
      bb_data = 1'b1;
    end
  end

  always_comb begin
    stall_d  = PC_EN   ? stall_q  : sat_inc(stall_q);
    bubble_d = bb_data ? sat_inc(bubble_q) : bubble_q;
    flush_d  = bb_bj   ? sat_inc(flush_q)  : flush_q;
  end

  always_ff @(posedge clk) begin
    if (CLR) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;

endmodule : hazard_stall_ctrl

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       CLR;
  logic [4:0] ID_rs, ID_rt, EX_WbRegNum;
  logic       ID_use_rs, ID_use_rt, ID_hilo_rd, ID_mdu_op;
  logic       EX_MemtoReg, EX_RegWrite, EX_mdu_start, EX_bj_taken;

  logic        PC_EN, IFID_EN, IFID_CLR, IDEX_EN, bb_data, bb_bj, mdu_busy;
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;

  // Narrow-counter instance: exercises saturation in a few cycles.
  logic       s_pc_en, s_ifid_en, s_ifid_clr, s_idex_en, s_bb_data, s_bb_bj, s_busy;
  logic [1:0] s_stall, s_bubble, s_flush;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_stall, exp_bubble, exp_flush;

  wire [5:0] ctrl = {PC_EN, IFID_EN, IFID_CLR, IDEX_EN, bb_data, bb_bj};
  localparam logic [5:0] C_RUN   = 6'b110100;
  localparam logic [5:0] C_STALL = 6'b000010;
  localparam logic [5:0] C_FLUSH = 6'b111001;

  hazard_stall_ctrl #(.MDU_LAT(8), .CNT_W(32)) dut (
    .clk(clk), .CLR(CLR), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .ID_hilo_rd(ID_hilo_rd),
    .ID_mdu_op(ID_mdu_op), .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite),
    .EX_WbRegNum(EX_WbRegNum), .EX_mdu_start(EX_mdu_start), .EX_bj_taken(EX_bj_taken),
    .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IFID_CLR(IFID_CLR), .IDEX_EN(IDEX_EN),
    .bb_data(bb_data), .bb_bj(bb_bj), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  hazard_stall_ctrl #(.MDU_LAT(8), .CNT_W(2)) dut_sat (
    .clk(clk), .CLR(CLR), .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .ID_hilo_rd(ID_hilo_rd),
    .ID_mdu_op(ID_mdu_op), .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite),
    .EX_WbRegNum(EX_WbRegNum), .EX_mdu_start(EX_mdu_start), .EX_bj_taken(EX_bj_taken),
    .PC_EN(s_pc_en), .IFID_EN(s_ifid_en), .IFID_CLR(s_ifid_clr), .IDEX_EN(s_idex_en),
    .bb_data(s_bb_data), .bb_bj(s_bb_bj), .mdu_busy(s_busy),
    .stall_cnt(s_stall), .bubble_cnt(s_bubble), .flush_cnt(s_flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_use_rs = 1'b0; ID_use_rt = 1'b0;
    ID_hilo_rd = 1'b0; ID_mdu_op = 1'b0;
    EX_MemtoReg = 1'b0; EX_RegWrite = 1'b0; EX_WbRegNum = 5'd0;
    EX_mdu_start = 1'b0; EX_bj_taken = 1'b0;
    #1;
  endtask

  task automatic set_load5();
    EX_MemtoReg = 1'b1; EX_RegWrite = 1'b1; EX_WbRegNum = 5'd5;
  endtask

  task automatic test_reset();
    idle_inputs();
    CLR = 1'b1;
    tick(); tick();
    CLR = 1'b0;
    #1;
    exp_stall = 0; exp_bubble = 0; exp_flush = 0;
    vectors++;
    if (ctrl !== C_RUN) begin
      errors++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_RUN);
    end
    vectors++;
    if (mdu_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", mdu_busy);
    end
    vectors++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== {exp_stall, exp_bubble, exp_flush}) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0", stall_cnt, bubble_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    // rs match
    set_load5(); ID_rs = 5'd5; ID_use_rs = 1'b1; #1;
    vectors++;
    if (ctrl !== C_STALL) begin
      errors++; $display("FAIL lu_rs_ctrl: got %b want %b", ctrl, C_STALL);
    end
    tick();
    exp_stall = 1; exp_bubble = 1;
    vectors++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== {exp_stall, exp_bubble, exp_flush}) begin
      errors++; $display("FAIL lu_rs_cnt: got %0d/%0d/%0d want %0d/%0d/%0d",
                         stall_cnt, bubble_cnt, flush_cnt, exp_stall, exp_bubble, exp_flush);
    end
    // rt match only
    ID_use_rs = 1'b0; ID_rs = 5'd0; ID_rt = 5'd5; ID_use_rt = 1'b1; #1;
    vectors++;
    if (ctrl !== C_STALL) begin
      errors++; $display("FAIL lu_rt_ctrl: got %b want %b", ctrl, C_STALL);
    end
    tick();
    exp_stall = 2; exp_bubble = 2;
    // match on rs but instruction does not read rs
    ID_use_rt = 1'b0; ID_rs = 5'd5; #1;
    vectors++;
    if (ctrl !== C_RUN) begin
      errors++; $display("FAIL lu_unused_ctrl: got %b want %b", ctrl, C_RUN);
    end
    // ALU producer, not a load
    ID_use_rs = 1'b1; EX_MemtoReg = 1'b0; #1;
    vectors++;
    if (ctrl !== C_RUN) begin
      errors++; $display("FAIL lu_alu_ctrl: got %b want %b", ctrl, C_RUN);
    end
    // load to $0 never stalls
    EX_MemtoReg = 1'b1; EX_WbRegNum = 5'd0; ID_rs = 5'd0; #1;
    vectors++;
    if (ctrl !== C_RUN) begin
      errors++; $display("FAIL lu_zero_ctrl: got %b want %b", ctrl, C_RUN);
    end
    tick();
    vectors++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== {exp_stall, exp_bubble, exp_flush}) begin
      errors++; $display("FAIL lu_zero_cnt: got %0d/%0d/%0d want %0d/%0d/%0d",
                         stall_cnt, bubble_cnt, flush_cnt, exp_stall, exp_bubble, exp_flush);
    end
    idle_inputs();
  endtask

  task automatic test_bj_priority();
    set_load5(); ID_rs = 5'd5; ID_use_rs = 1'b1; EX_bj_taken = 1'b1; #1;
    vectors++;
    if (ctrl !== C_FLUSH) begin
      errors++; $display("FAIL bj_prio_ctrl: got %b want %b", ctrl, C_FLUSH);
    end
    tick();
    exp_flush = 1;
    vectors++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== {exp_stall, exp_bubble, exp_flush}) begin
      errors++; $display("FAIL bj_prio_cnt: got %0d/%0d/%0d want %0d/%0d/%0d",
                         stall_cnt, bubble_cnt, flush_cnt, exp_stall, exp_bubble, exp_flush);
    end
    idle_inputs();
  endtask

  task automatic test_mdu_window();
    // cycle T: start with a HI/LO reader already in ID
    EX_mdu_start = 1'b1; ID_hilo_rd = 1'b1; #1;
    vectors++;
    if ({ctrl, mdu_busy} !== {C_STALL, 1'b0}) begin
      errors++; $display("FAIL mdu_T: got ctrl=%b busy=%b want %b/0", ctrl, mdu_busy, C_STALL);
    end
    tick();
    EX_mdu_start = 1'b0; #1;
    for (int k = 1; k <= 8; k++) begin
      vectors++;
      if ({ctrl, mdu_busy} !== {C_STALL, 1'b1}) begin
        errors++; $display("FAIL mdu_T+%0d: got ctrl=%b busy=%b want %b/1", k, ctrl, mdu_busy, C_STALL);
      end
      tick();
    end
    vectors++;
    if ({ctrl, mdu_busy} !== {C_RUN, 1'b0}) begin
      errors++; $display("FAIL mdu_T+9: got ctrl=%b busy=%b want %b/0", ctrl, mdu_busy, C_RUN);
    end
    exp_stall = exp_stall + 9; exp_bubble = exp_bubble + 9;
    vectors++;
    if ({stall_cnt, bubble_cnt, flush_cnt} !== {exp_stall, exp_bubble, exp_flush}) begin
      errors++; $display("FAIL mdu_cnt: got %0d/%0d/%0d want %0d/%0d/%0d",
                         stall_cnt, bubble_cnt, flush_cnt, exp_stall, exp_bubble, exp_flush);
    end
    // MDU op in ID behind a busy MDU also stalls; branch does not abort MDU
    idle_inputs();
    EX_mdu_start = 1'b1; tick(); EX_mdu_start = 1'b0;
    ID_mdu_op = 1'b1; #1;
    vectors++;
    if (ctrl !== C_STALL) begin
      errors++; $display("FAIL mdu_op_ctrl: got %b want %b", ctrl, C_STALL);
    end
    EX_bj_taken = 1'b1; #1;
    vectors++;
    if (ctrl !== C_FLUSH) begin
      errors++; $display("FAIL mdu_bj_ctrl: got %b want %b", ctrl, C_FLUSH);
    end
    tick();
    vectors++;
    if (mdu_busy !== 1'b1) begin
      errors++; $display("FAIL mdu_bj_busy: got %b want 1", mdu_busy);
    end
    idle_inputs();
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_clr_busy();
    EX_mdu_start = 1'b1; tick(); EX_mdu_start = 1'b0;
    tick(); tick(); tick(); tick();   // counter now 3, still busy
    vectors++;
    if (mdu_busy !== 1'b1) begin
      errors++; $display("FAIL clr_pre_busy: got %b want 1", mdu_busy);
    end
    CLR = 1'b1; tick(); CLR = 1'b0;
    ID_hilo_rd = 1'b1; #1;
    exp_stall = 0; exp_bubble = 0; exp_flush = 0;
    vectors++;
    if ({ctrl, mdu_busy} !== {C_RUN, 1'b0}) begin
      errors++; $display("FAIL clr_ctrl: got ctrl=%b busy=%b want %b/0", ctrl, mdu_busy, C_RUN);
    end
    vectors++;
    if ({stall_cnt, bubble_cnt, flush_cnt, s_stall} !== {exp_stall, exp_bubble, exp_flush, 2'd0}) begin
      errors++; $display("FAIL clr_cnt: got %0d/%0d/%0d sat=%0d want 0/0/0 sat=0",
                         stall_cnt, bubble_cnt, flush_cnt, s_stall);
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    set_load5(); ID_rs = 5'd5; ID_use_rs = 1'b1; #1;
    tick(); tick();
    vectors++;
    if ({s_stall, stall_cnt} !== {2'd2, 32'd2}) begin
      errors++; $display("FAIL sat_pre: got narrow=%0d wide=%0d want 2/2", s_stall, stall_cnt);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if ({s_stall, s_bubble, stall_cnt} !== {2'd3, 2'd3, 32'(2 + k)}) begin
        errors++; $display("FAIL sat_hold%0d: got stall=%0d bubble=%0d wide=%0d want 3/3/%0d",
                           k, s_stall, s_bubble, stall_cnt, 2 + k);
      end
    end
    idle_inputs();
  endtask

  initial begin
    CLR = 1'b0;
    test_reset();
    test_load_use();
    test_bj_priority();
    test_mdu_window();
    test_clr_busy();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_hazard_stall_ctrl
